// File: rtl/forward_layer_engine.sv
// Fully connected layer: z = W*x + b in signed fixed point, then a = act(z), one MAC per enabled cycle.
// Latency N_OUT*(N_IN+1) enabled cycles; the result is held in DONE until out_ready, and in_ready is low while busy.
module forward_layer_engine #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 2*DW + $clog2(N_IN) + 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*DW-1:0]       x,
  input  logic [N_OUT*N_IN*DW-1:0] W,
  input  logic [N_OUT*DW-1:0]      b,
  input  logic [1:0]               act_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT*DW-1:0]      z,
  output logic [N_OUT*DW-1:0]      a,
  output logic                     busy
);

  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, FINAL, DONE} state_t;

  state_t                     state, state_nxt;
  logic [IW-1:0]              i_cnt;
  logic [JW-1:0]              j_cnt, j_inc;
  logic signed [ACC_W-1:0]    acc, acc_sh;
  logic [N_IN*DW-1:0]         x_q;
  logic [N_OUT*N_IN*DW-1:0]   w_q;
  logic [N_OUT*DW-1:0]        b_q;
  logic [1:0]                 mode_q;
  logic signed [DW-1:0]       x_sel, w_sel, r, act_r;
  logic signed [2*DW-1:0]     prod;

  // Bias enters the accumulator already aligned to the product's 2*FRAC scaling.
  function automatic logic signed [ACC_W-1:0] bias_ext(input logic [DW-1:0] v);
    bias_ext = $signed({{(ACC_W-DW){v[DW-1]}}, v}) <<< FRAC;
  endfunction

  assign in_ready  = (state == IDLE) & enable & ~reset;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    x_sel  = x_q[int'(i_cnt)*DW +: DW];
    w_sel  = w_q[(int'(j_cnt)*N_IN + int'(i_cnt))*DW +: DW];
    prod   = x_sel * w_sel;
    acc_sh = acc >>> FRAC;
    j_inc  = (j_cnt == J_LAST) ? j_cnt : j_cnt + 1'b1;
    if (acc_sh > SAT_MAX)      r = {1'b0, {(DW-1){1'b1}}};
    else if (acc_sh < SAT_MIN) r = {1'b1, {(DW-1){1'b0}}};
    else                       r = acc_sh[DW-1:0];
    case (mode_q)
      2'd1:    act_r = r[DW-1] ? '0 : r;
      2'd2:    act_r = r[DW-1] ? (r >>> 3) : r;
      default: act_r = r;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid && in_ready) state_nxt = MAC;
      MAC:   if (i_cnt == I_LAST) state_nxt = FINAL;
      FINAL: state_nxt = (j_cnt == J_LAST) ? DONE : MAC;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)       state <= IDLE;
    else if (enable) state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_cnt <= '0;
      j_cnt <= '0;
      acc   <= '0;
      z     <= '0;
      a     <= '0;
    end else if (enable) begin
      case (state)
        IDLE: if (in_valid) begin
          x_q    <= x;
          w_q    <= W;
          b_q    <= b;
          mode_q <= act_mode;
          i_cnt  <= '0;
          j_cnt  <= '0;
          acc    <= bias_ext(b[DW-1:0]);
        end
        MAC: begin
          acc   <= acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
          i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + 1'b1;
        end
        FINAL: begin
          z[int'(j_cnt)*DW +: DW] <= r;
          a[int'(j_cnt)*DW +: DW] <= act_r;
          if (j_cnt != J_LAST) begin
            j_cnt <= j_inc;
            acc   <= bias_ext(b_q[int'(j_inc)*DW +: DW]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_forward_layer_engine.sv
// Directed bench for forward_layer_engine at N_IN=2, N_OUT=2, DW=16, FRAC=8.
module tb_forward_layer_engine;

  logic        clk = 1'b0;
  logic        reset, enable, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] x, b, z, a;
  logic [63:0] W;
  logic [1:0]  act_mode;
  int          errors = 0;
  int          checks = 0;

  localparam logic [31:0] X_A = {16'h0200, 16'h0100};
  localparam logic [63:0] W_A = {16'h0080, 16'hFF00, 16'h0100, 16'h0100};
  localparam logic [31:0] B_A = {16'h0080, 16'h0000};
  localparam logic [31:0] Z_A = {16'h0080, 16'h0300};
  localparam logic [31:0] X_L = {16'h0000, 16'h0100};
  localparam logic [63:0] W_L = {16'h0000, 16'hFE00, 16'h0000, 16'hFF00};
  localparam logic [31:0] Z_L = {16'hFE00, 16'hFF00};
  localparam logic [31:0] A_L = {16'hFFC0, 16'hFFE0};

  forward_layer_engine #(.N_IN(2), .N_OUT(2), .DW(16), .FRAC(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .W(W), .b(b), .act_mode(act_mode), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .a(a), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present an operand set, scramble the inputs after acceptance, count edges until out_valid.
  task automatic run_op(input logic [31:0] xv, input logic [63:0] wv, input logic [31:0] bv,
                        input logic [1:0] mode, output int lat, output bit busy_ok);
    x = xv; W = wv; b = bv; act_mode = mode; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x = $urandom; W = {$urandom, $urandom}; b = $urandom; act_mode = 2'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; W = '0; b = '0; act_mode = 2'd0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during: got %b want 0", in_ready); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b out_valid=%b want 0 0", busy, out_valid); end
    checks++; if (z !== 32'h0 || a !== 32'h0) begin errors++; $display("FAIL reset_outputs: z=%h a=%h want 0 0", z, a); end
  endtask

  task automatic test_relu;
    int lat; bit bok;
    run_op(X_A, W_A, B_A, 2'd1, lat, bok);
    checks++; if (lat !== 6) begin errors++; $display("FAIL relu_latency: got %0d want 6", lat); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL relu_busy: busy dropped while computing"); end
    checks++; if (z !== Z_A) begin errors++; $display("FAIL relu_z: got %h want %h", z, Z_A); end
    checks++; if (a !== Z_A) begin errors++; $display("FAIL relu_a: got %h want %h", a, Z_A); end
    finish_op();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL relu_idle: busy=%b in_ready=%b want 0 1", busy, in_ready); end
  endtask

  task automatic test_saturation;
    int lat; bit bok;
    run_op({2{16'h7FFF}}, {4{16'h7FFF}}, {16'h8000, 16'h7FFF}, 2'd0, lat, bok);
    checks++; if (z !== 32'h7FFF7FFF || a !== 32'h7FFF7FFF) begin errors++; $display("FAIL sat_pos: z=%h a=%h want 7fff7fff", z, a); end
    finish_op();
    run_op({2{16'h7FFF}}, {4{16'h8000}}, {16'h8000, 16'h7FFF}, 2'd3, lat, bok);
    checks++; if (z !== 32'h80008000 || a !== 32'h80008000) begin errors++; $display("FAIL sat_neg: z=%h a=%h want 80008000", z, a); end
    finish_op();
  endtask

  task automatic test_leaky;
    int lat; bit bok;
    run_op(X_L, W_L, 32'h0, 2'd2, lat, bok);
    checks++; if (z !== Z_L) begin errors++; $display("FAIL leaky_z: got %h want %h", z, Z_L); end
    checks++; if (a !== A_L) begin errors++; $display("FAIL leaky_a: got %h want %h", a, A_L); end
    finish_op();
    run_op(X_L, W_L, 32'h0, 2'd1, lat, bok);
    checks++; if (z !== Z_L || a !== 32'h0) begin errors++; $display("FAIL relu_neg: z=%h a=%h want %h 0", z, a, Z_L); end
    finish_op();
  endtask

  task automatic test_hold;
    int lat; bit bok;
    run_op(X_A, W_A, B_A, 2'd0, lat, bok);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || z !== Z_A || a !== Z_A || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: out_valid=%b z=%h a=%h in_ready=%b want 1 %h %h 0", k, out_valid, z, a, in_ready, Z_A, Z_A);
      end
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL handoff_in_ready: got %b want 0", in_ready); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL handoff_idle: out_valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    int lat; bit bok;
    run_op(X_L, W_L, 32'h0, 2'd2, lat, bok);
    checks++; if (lat !== 6 || z !== Z_L || a !== A_L) begin
      errors++; $display("FAIL b2b: lat=%0d z=%h a=%h want 6 %h %h", lat, z, a, Z_L, A_L);
    end
    finish_op();
  endtask

  task automatic test_reset_mid;
    run_op(X_A, W_A, B_A, 2'd1, lat_dummy, bok_dummy);
    finish_op();
    x = X_L; W = W_L; b = 32'h0; act_mode = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_flags: out_valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
    checks++; if (z !== 32'h0 || a !== 32'h0) begin errors++; $display("FAIL reset_mid_outputs: z=%h a=%h want 0 0", z, a); end
    seen_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_abandon: out_valid rose after reset, want 0"); end
  endtask

  int lat_dummy;
  bit bok_dummy;
  bit seen_valid;

  task automatic test_enable_stall;
    int lat;
    x = X_A; W = W_A; b = B_A; act_mode = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x = $urandom; W = {$urandom, $urandom}; b = $urandom;
    tick();
    lat = 1;
    enable = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    for (int k = 0; k < 4; k++) begin tick(); lat++; end
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_frozen: busy=%b out_valid=%b want 1 0", busy, out_valid); end
    enable = 1'b1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    checks++; if (lat !== 10) begin errors++; $display("FAIL stall_latency: got %0d want 10", lat); end
    checks++; if (z !== Z_A || a !== Z_A) begin errors++; $display("FAIL stall_result: z=%h a=%h want %h %h", z, a, Z_A, Z_A); end
    enable = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || z !== Z_A) begin errors++; $display("FAIL stall_done_frozen: out_valid=%b z=%h want 1 %h", out_valid, z, Z_A); end
    enable = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_handoff: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_relu();
    test_saturation();
    test_leaky();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_enable_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/forward_layer_engine.md
FORWARD_LAYER_ENGINE -- requirements
Module: forward_layer_engine

Interface
REQ-001 Parameter N_IN, default 4: number of inputs per neuron (>=1).
REQ-002 Parameter N_OUT, default 4: number of neurons in the layer (>=1).
REQ-003 Parameter DW, default 16: signed two's-complement data width.
REQ-004 Parameter FRAC, default 8: fractional bits of the fixed-point format (0 < FRAC < DW).
REQ-005 Parameter ACC_W, default 2*DW+clog2(N_IN)+2: accumulator width.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  global clock-enable; low freezes all state.
REQ-009 in_valid  in  1  operand set on x/W/b/act_mode is valid.
REQ-010 in_ready  out  1  engine can accept an operand set.
REQ-011 x  in  N_IN*DW  input vector; element i at bits [i*DW +: DW].
REQ-012 W  in  N_OUT*N_IN*DW  weights; W[j][i] at bits [(j*N_IN+i)*DW +: DW].
REQ-013 b  in  N_OUT*DW  bias vector; b[j] at bits [j*DW +: DW].
REQ-014 act_mode  in  2  0 linear, 1 ReLU, 2 leaky ReLU, 3 treated as linear.
REQ-015 out_valid  out  1  z/a hold a completed result.
REQ-016 out_ready  in  1  consumer accepts the result.
REQ-017 z  out  N_OUT*DW  pre-activation vector, same packing as b.
REQ-018 a  out  N_OUT*DW  activated vector, same packing as b.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states IDLE, MAC, FINAL, DONE; reset state IDLE.
REQ-021 in_ready SHALL equal (state==IDLE) & enable & ~reset.
REQ-022 On an edge with in_valid & in_ready: register x, W, b and act_mode internally; enter MAC with neuron j=0, input i=0, and acc loaded with sign-extended b[0] shifted left by FRAC.
REQ-023 Inputs are sampled only on the acceptance edge; later changes on x/W/b/act_mode have no effect on the current operation.
REQ-024 MAC: one signed product W[j][i]*x[i] added to acc per enabled cycle; i increments; after i==N_IN-1, go to FINAL.
REQ-025 FINAL (one cycle): r = acc >>> FRAC (arithmetic shift, truncation toward -inf), saturated to [-2^(DW-1), 2^(DW-1)-1]; write z[j]=r and a[j]=act(r).
REQ-026 act(r): linear -> r; ReLU -> max(r,0); leaky -> r if r>=0 else r>>>3.
REQ-027 After FINAL: if j<N_OUT-1, increment j, reset i=0, reload acc from b[j+1]<<FRAC, return to MAC; otherwise go to DONE.
REQ-028 out_valid SHALL be high exactly while in DONE, rising N_OUT*(N_IN+1) enabled edges after the acceptance edge.
REQ-029 In DONE, z, a and out_valid are held stable until out_valid & out_ready & enable; then IDLE on that edge.
REQ-030 A new operand set cannot be accepted in the same cycle as output handoff; the earliest next acceptance is the following cycle.
REQ-031 z and a are only written in FINAL, so partially computed vectors are never flagged valid.
REQ-032 enable low: FSM, counters, acc, z, a frozen; out_valid keeps its value; in_ready low; latency extends by the number of disabled cycles.
REQ-033 The accumulator SHALL NOT overflow for any operands at ACC_W default; saturation occurs only in FINAL.

Reset
REQ-034 On a reset edge, regardless of enable or state: state=IDLE, i=j=0, acc=0, z=0, a=0, out_valid=0, busy=0; in_ready=1 on the first cycle after reset deasserts with enable high.
REQ-035 Reset mid-operation abandons the operation with no output handshake.

Verification (N_IN=2, N_OUT=2, DW=16, FRAC=8)
REQ-036 x=[256,512], W=[[256,256],[-256,128]], b=[0,128], ReLU -> out_valid 6 edges after acceptance; z=[768,128], a=[768,128]; busy high for those 6 cycles.
REQ-037 x=[32767,32767], W all 32767, b=[32767,-32768], linear -> z=a=[32767,32767] (positive saturation); W all -32768 with x all 32767 -> z=[-32768,-32768].
REQ-038 x=[256,0], W=[[-256,0],[-512,0]], b=[0,0], leaky -> z=[-256,-512], a=[-32,-64]; same with ReLU -> a=[0,0].
REQ-039 Hold out_ready low 5 cycles after out_valid -> out_valid, z, a stable, in_ready low; out_ready high -> IDLE next edge, in_ready high.
REQ-040 Reset on the 3rd cycle of MAC -> next cycle out_valid=0, z=a=0, busy=0, in_ready=1; enable low for 4 cycles mid-MAC -> out_valid 10 edges after acceptance with the REQ-036 results.
